// File: rtl/pid_controller.sv
// pid_controller: sequential fixed-point PID with a single shared multiplier.
// Each accepted error sample walks IDLE -> P -> I -> D -> SUM and produces a
// saturated unsigned drive command with conditional-integration anti-windup.
module pid_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 10,
    parameter int FRAC_BITS  = 4,
    parameter int INT_LIMIT  = 1048576
) (
    input  logic                         clk_div,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] error,
    input  logic        [7:0]            Kp,
    input  logic        [7:0]            Ki,
    input  logic        [6:0]            Kd,
    output logic                         busy,
    output logic                         out_valid,
    output logic        [OUT_WIDTH-1:0]  ctrl_out
);

    // Gain operand is 9-bit signed (zero-extended gain), data operand is the
    // 17-bit signed error/difference; the full product is kept for the terms.
    localparam int OPB_W  = DATA_WIDTH + 1;
    localparam int PROD_W = OPB_W + 9;
    localparam int INT_W  = 32;
    localparam int SUM_W  = 34;

    localparam logic signed [INT_W:0]   LIM_POS = (INT_W + 1)'(INT_LIMIT);
    localparam logic signed [INT_W:0]   LIM_NEG = -LIM_POS;
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((64'd1 << OUT_WIDTH) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P    = 3'd1,
        S_I    = 3'd2,
        S_D    = 3'd3,
        S_SUM  = 3'd4
    } state_t;

    state_t                         r_state;
    logic signed [DATA_WIDTH-1:0]   r_err;
    logic signed [DATA_WIDTH-1:0]   r_prev_err;
    logic        [7:0]              r_kp;
    logic        [7:0]              r_ki;
    logic        [6:0]              r_kd;
    logic signed [PROD_W-1:0]       r_p_term;
    logic signed [PROD_W-1:0]       r_d_term;
    logic signed [INT_W-1:0]        r_integ;
    logic                           r_first_flag;
    logic                           r_sat_hi;
    logic                           r_sat_lo;
    logic                           r_busy;
    logic                           r_out_valid;
    logic        [OUT_WIDTH-1:0]    r_ctrl_out;

    logic signed [8:0]              w_mul_a;
    logic signed [OPB_W-1:0]        w_mul_b;
    logic signed [PROD_W-1:0]       w_mul_p;
    logic signed [INT_W:0]          w_int_sum;
    logic signed [INT_W-1:0]        w_int_next;
    logic                           w_int_skip;
    logic signed [SUM_W-1:0]        w_sum;
    logic signed [SUM_W-1:0]        w_s;

    // Shared multiplier operand selection by state, plus integrator and sum datapath.
    always_comb begin
        w_mul_a = 9'sd0;
        w_mul_b = '0;
        case (r_state)
            S_P: begin
                w_mul_a = {1'b0, r_kp};
                w_mul_b = {r_err[DATA_WIDTH-1], r_err};
            end
            S_I: begin
                w_mul_a = {1'b0, r_ki};
                w_mul_b = {r_err[DATA_WIDTH-1], r_err};
            end
            S_D: begin
                w_mul_a = {2'b00, r_kd};
                w_mul_b = {r_err[DATA_WIDTH-1], r_err} - {r_prev_err[DATA_WIDTH-1], r_prev_err};
            end
            default: begin
                w_mul_a = 9'sd0;
                w_mul_b = '0;
            end
        endcase
        w_mul_p = w_mul_a * w_mul_b;

        // Integrator update is saturated, never wrapped.
        w_int_sum = {r_integ[INT_W-1], r_integ}
                  + {{(INT_W + 1 - PROD_W){w_mul_p[PROD_W-1]}}, w_mul_p};
        if (w_int_sum > LIM_POS) begin
            w_int_next = LIM_POS[INT_W-1:0];
        end else if (w_int_sum < LIM_NEG) begin
            w_int_next = LIM_NEG[INT_W-1:0];
        end else begin
            w_int_next = w_int_sum[INT_W-1:0];
        end

        // Freeze the integrator while the output is pinned in the same direction.
        w_int_skip = (r_sat_hi && !r_err[DATA_WIDTH-1] && (r_err != '0))
                  || (r_sat_lo && r_err[DATA_WIDTH-1]);

        w_sum = {{(SUM_W - PROD_W){r_p_term[PROD_W-1]}}, r_p_term}
              + {{(SUM_W - INT_W){r_integ[INT_W-1]}}, r_integ}
              + {{(SUM_W - PROD_W){r_d_term[PROD_W-1]}}, r_d_term};
        w_s   = w_sum >>> FRAC_BITS;
    end

    // Sample sequencer: state, latched operands, PID state and registered outputs.
    always_ff @(posedge clk_div) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_err        <= '0;
            r_prev_err   <= '0;
            r_kp         <= 8'd0;
            r_ki         <= 8'd0;
            r_kd         <= 7'd0;
            r_p_term     <= '0;
            r_d_term     <= '0;
            r_integ      <= '0;
            r_first_flag <= 1'b1;
            r_sat_hi     <= 1'b0;
            r_sat_lo     <= 1'b0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_ctrl_out   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sample_valid) begin
                        r_err   <= error;
                        r_kp    <= Kp;
                        r_ki    <= Ki;
                        r_kd    <= Kd;
                        r_busy  <= 1'b1;
                        r_state <= S_P;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_P: begin
                    r_p_term <= w_mul_p;
                    r_state  <= S_I;
                end
                S_I: begin
                    if (!w_int_skip) begin
                        r_integ <= w_int_next;
                    end else begin
                        r_integ <= r_integ;
                    end
                    r_state <= S_D;
                end
                S_D: begin
                    if (r_first_flag) begin
                        r_d_term <= '0;
                    end else begin
                        r_d_term <= w_mul_p;
                    end
                    r_state <= S_SUM;
                end
                S_SUM: begin
                    if (w_s < 0) begin
                        r_ctrl_out <= '0;
                    end else if (w_s > OUT_MAX) begin
                        r_ctrl_out <= OUT_MAX[OUT_WIDTH-1:0];
                    end else begin
                        r_ctrl_out <= w_s[OUT_WIDTH-1:0];
                    end
                    r_sat_hi     <= (w_s > OUT_MAX);
                    r_sat_lo     <= (w_s < 0);
                    r_prev_err   <= r_err;
                    r_first_flag <= 1'b0;
                    r_out_valid  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign ctrl_out  = r_ctrl_out;

endmodule

// File: tb/tb_pid_controller.sv
// Testbench for pid_controller: directed vectors, expected commands queued at
// issue time and compared by an independent monitor on each out_valid pulse.
module tb_pid_controller;

    logic               clk_div;
    logic               reset;
    logic               sample_valid;
    logic signed [15:0] error;
    logic        [7:0]  Kp;
    logic        [7:0]  Ki;
    logic        [6:0]  Kd;
    logic               busy;
    logic               out_valid;
    logic        [9:0]  ctrl_out;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int n_out   = 0;

    pid_controller #(
        .DATA_WIDTH(16),
        .OUT_WIDTH (10),
        .FRAC_BITS (4),
        .INT_LIMIT (1048576)
    ) dut (
        .clk_div     (clk_div),
        .reset       (reset),
        .sample_valid(sample_valid),
        .error       (error),
        .Kp          (Kp),
        .Ki          (Ki),
        .Kd          (Kd),
        .busy        (busy),
        .out_valid   (out_valid),
        .ctrl_out    (ctrl_out)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk_div) begin
        if (out_valid === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk($sformatf("ctrl_out[%0d]", n_out), int'(ctrl_out), e);
            end
        end
    end

    // Issue one sample and wait until its result is due (after E4).
    task automatic send(input logic signed [15:0] e, input logic [7:0] kp,
                        input logic [7:0] ki, input logic [6:0] kd, input int exp);
        @(negedge clk_div);
        error = e; Kp = kp; Ki = ki; Kd = kd; sample_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk_div);
        #1 sample_valid = 1'b0;
        repeat (4) @(posedge clk_div);
        #1 chk("latency_out_valid", int'(out_valid), 1);
    endtask

    task automatic do_reset();
        @(negedge clk_div);
        reset = 1'b1;
        repeat (2) @(posedge clk_div);
        @(negedge clk_div);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; error = 16'sd0;
        Kp = 8'd0; Ki = 8'd0; Kd = 7'd0;

        // Reset state
        repeat (2) @(posedge clk_div);
        #1;
        chk("reset_ctrl_out", int'(ctrl_out), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk_div);
        reset = 1'b0;

        send(16'sd500, 8'd0, 8'd0, 7'd0, 0);

        // Proportional with explicit busy/latency profile: 400 >> 4 = 25
        @(negedge clk_div);
        error = 16'sd100; Kp = 8'd4; Ki = 8'd0; Kd = 7'd0; sample_valid = 1'b1;
        exp_q.push_back(25);
        @(posedge clk_div);
        #1 sample_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("busy_E%0d", k), int'(busy), 1);
            chk($sformatf("no_out_valid_E%0d", k), int'(out_valid), 0);
            @(posedge clk_div);
            #1;
        end
        chk("busy_E4", int'(busy), 0);
        chk("out_valid_E4", int'(out_valid), 1);

        send(-16'sd100, 8'd4, 8'd0, 7'd0, 0);          // -25 clamps to 0, sat_lo

        // Integral: 32, 64, 96 -> 2, 4, 6
        send(16'sd16, 8'd0, 8'd2, 7'd0, 2);
        send(16'sd16, 8'd0, 8'd2, 7'd0, 4);
        send(16'sd16, 8'd0, 8'd2, 7'd0, 6);
        send(16'sd32767, 8'd0, 8'd255, 7'd0, 1023);     // integrator pinned
        send(16'sd32767, 8'd0, 8'd255, 7'd0, 1023);
        send(16'sd100, 8'd0, 8'd255, 7'd0, 1023);

        // Anti-windup made observable through a freshly cleared integrator
        do_reset();
        send(16'sd1000, 8'd255, 8'd0, 7'd0, 1023);      // P alone saturates high
        send(16'sd16, 8'd0, 8'd1, 7'd0, 0);             // skipped: integ stays 0
        send(16'sd16, 8'd0, 8'd1, 7'd0, 1);             // integ 16 -> 1
        send(-16'sd1000, 8'd255, 8'd0, 7'd0, 0);        // saturates low
        send(-16'sd16, 8'd0, 8'd1, 7'd0, 1);            // skipped: integ stays 16

        // Derivative
        do_reset();
        send(16'sd64, 8'd0, 8'd0, 7'd8, 0);             // first sample, D forced 0
        send(16'sd128, 8'd0, 8'd0, 7'd8, 32);           // 8*64 >> 4
        send(16'sd0, 8'd0, 8'd0, 7'd8, 0);              // -64 clamps to 0

        // Handshake: strobes at E1/E2 ignored, gains latched at E0
        @(negedge clk_div);
        error = 16'sd160; Kp = 8'd4; Ki = 8'd0; Kd = 7'd0; sample_valid = 1'b1;
        exp_q.push_back(40);
        @(posedge clk_div);
        #1 error = 16'sd800; Kp = 8'd8;
        @(posedge clk_div);
        @(posedge clk_div);
        #1 sample_valid = 1'b0;
        @(posedge clk_div);
        @(posedge clk_div);
        #1 chk("handshake_out_valid_E4", int'(out_valid), 1);
        send(16'sd80, 8'd4, 8'd0, 7'd0, 20);            // strobe coincident with out_valid

        // Reset while in state I aborts the sample
        @(negedge clk_div);
        error = 16'sd100; Kp = 8'd0; Ki = 8'd10; Kd = 7'd0; sample_valid = 1'b1;
        @(posedge clk_div);
        #1 sample_valid = 1'b0;
        @(posedge clk_div);
        @(negedge clk_div);
        reset = 1'b1;
        @(posedge clk_div);
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_out_valid", int'(out_valid), 0);
        @(negedge clk_div);
        reset = 1'b0;
        repeat (6) @(posedge clk_div);
        send(16'sd16, 8'd0, 8'd10, 7'd0, 10);

        repeat (8) @(posedge clk_div);
        #1 chk("pending_expectations", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
